// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-port responder: word geometry,
// latency counter width, FSM state encoding and the misalignment test.
package dmem_pkg;

  // Data word width and the number of byte-offset bits below the word index.
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;

  // Latency counter width; LATENCY must fit in it (1..15).
  localparam int CNT_W    = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A byte address is misaligned when any byte-offset bit is set.
  function automatic logic is_misaligned(input logic [OFFSET_W-1:0] offset);
    return offset != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data store: synchronous write, combinational read.
// Contents are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Commit a store on the clock edge when the responder performs the access.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Loads see the current word immediately; the responder registers it.
  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage data port. Accepts one load/store
// at a time over valid/ready, waits a fixed latency, performs the access and
// holds the response until the initiator takes it. `busy` stalls the pipeline
// while a request is outstanding.
// Optional feature macro: DMEM_MISALIGN_CHK_EN -- when defined, accesses with
// nonzero byte offset are flagged on rsp_err, stores are suppressed and loads
// return zero. When undefined, the byte offset is ignored and rsp_err is 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  // Reject configurations the counter or address slicing cannot represent.
  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
      $error("dmem_responder: ADDR_W must be in 1..29");
    end
  endgenerate

  // The counter is loaded with LATENCY and the access happens on the edge
  // where it is found at zero, so the response appears LATENCY+1 edges after
  // the accept edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic                we_reg;
  logic [ADDR_W-1:0]   idx_reg;
  logic [WORD_W-1:0]   wdata_reg;
  logic                mis_reg;

  logic [WORD_W-1:0]   rdata_reg;
  logic                err_reg;

  logic                accept;
  logic                access;
  logic                mis_next;
  logic                mem_we;
  logic [WORD_W-1:0]   mem_rdata;
  logic [ADDR_W-1:0]   req_idx;

  // Word index: upper address bits are dropped, so addresses wrap on depth.
  assign req_idx = req_addr[ADDR_W+OFFSET_W-1:OFFSET_W];

`ifdef DMEM_MISALIGN_CHK_EN
  assign mis_next = is_misaligned(req_addr[OFFSET_W-1:0]);

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+OFFSET_W];
`else
  assign mis_next = 1'b0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+OFFSET_W], req_addr[OFFSET_W-1:0]};
`endif

  // State and latency counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    access     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request on accept; it stays put for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      mis_reg   <= 1'b0;
    end else if (accept) begin
      we_reg    <= req_we;
      idx_reg   <= req_idx;
      wdata_reg <= req_wdata;
      mis_reg   <= mis_next;
    end
  end

  // Stores commit only on the WAIT->RESP edge, so a reset before it aborts
  // the write; flagged stores never reach the array.
  assign mem_we = access & we_reg & ~mis_reg;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx_reg),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  // Response registers: loaded at the access edge, held stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (access) begin
      rdata_reg <= (we_reg || mis_reg) ? '0 : mem_rdata;
      err_reg   <= mis_reg;
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes the expected
// response of each accepted request (from a word-array model) into a queue;
// a monitor pops and compares whenever a response is handed over, and also
// checks response latency, response stability under backpressure and that
// the responder refuses requests while busy.
module tb_dmem_responder;

  localparam int AW  = 8;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    logic        we;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rsp_n  = 0;
  bit   force_hold = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] model_mem [2**AW];

  dmem_responder #(
    .ADDR_W  (AW),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic model_mis(input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one request from a negedge; push its expected response on accept.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit track);
    int          n;
    exp_t        e;
    logic [AW-1:0] idx;
    logic        mis;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      idx = addr[AW+1:2];
      mis = model_mis(addr);
      e.we      = we;
      e.addr    = addr;
      e.err     = mis;
      e.acc_cyc = cyc;
      if (we) begin
        e.rdata = 32'h0;
        if (!mis) model_mem[idx] = wdata;
      end else begin
        e.rdata = mis ? 32'h0 : model_mem[idx];
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait until every tracked response is consumed and the responder is idle.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain: got pending=%0d req_ready=%b required 0 and 1",
               exp_q.size(), req_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ready=%b valid=%b busy=%b rdata=%h err=%b required 1 0 0 00000000 0",
               tag, req_ready, rsp_valid, busy, rsp_rdata, rsp_err);
    end
  endtask

  // Monitor: drives rsp_ready and checks every response handed over.
  initial begin
    bit          in_resp;
    int          hold;
    int          lat;
    logic [31:0] held_rdata;
    logic        held_err;
    exp_t        e;
    in_resp   = 1'b0;
    hold      = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        in_resp   = 1'b0;
        hold      = 0;
        rsp_ready = 1'b0;
      end else if (rsp_valid === 1'b1) begin
        if (!in_resp) begin
          in_resp    = 1'b1;
          held_rdata = rsp_rdata;
          held_err   = rsp_err;
          hold       = force_hold ? 5 : int'($urandom_range(0, 2));
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h required no response", rsp_rdata);
          end else begin
            lat = cyc - exp_q[0].acc_cyc - 1;
            if (lat != LAT + 1) begin
              errors++;
              $display("FAIL latency: got %0d edges after accept required %0d", lat, LAT + 1);
            end
          end
        end else begin
          checks++;
          if (rsp_rdata !== held_rdata || rsp_err !== held_err) begin
            errors++;
            $display("FAIL rsp_stable: got rdata=%h err=%b required rdata=%h err=%b",
                     rsp_rdata, rsp_err, held_rdata, held_err);
          end
        end
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_resp: got req_ready=%b busy=%b required 0 1", req_ready, busy);
        end
        if (hold > 0) begin
          rsp_ready = 1'b0;
          hold--;
        end else begin
          rsp_ready = 1'b1;
          in_resp   = 1'b0;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            rsp_n++;
            checks++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
              errors++;
              $display("FAIL rsp_data: %s addr=%h got rdata=%h err=%b required rdata=%h err=%b",
                       e.we ? "sw" : "lw", e.addr, rsp_rdata, rsp_err, e.rdata, e.err);
            end else begin
              $display("rsp %0d: %s addr=%h rdata=%h err=%b", rsp_n,
                       e.we ? "sw" : "lw", e.addr, rsp_rdata, rsp_err);
            end
          end
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Stimulus.
  initial begin
    logic [31:0] a;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    // Reset asserted mid-cycle takes effect immediately.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset_idle");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Give every word a known value.
    for (int i = 0; i < 2**AW; i++) begin
      issue(1'b1, 32'(i) << 2, $urandom, 1'b1);
    end
    wait_idle();

    // Store then load.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    wait_idle();

    // Address wrap: 0x400 aliases word 0.
    issue(1'b1, 32'h400, 32'h12345678, 1'b1);
    issue(1'b0, 32'h000, 32'h0, 1'b1);
    wait_idle();

    // Backpressure with a concurrent request that must be ignored.
    force_hold = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h00000BAD;
    req_valid = 1'b1;
    repeat (5) @(negedge clk);
    req_valid  = 1'b0;
    force_hold = 1'b0;
    wait_idle();
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    wait_idle();

    // Reset in WAIT aborts a store.
    issue(1'b1, 32'h20, 32'h0, 1'b1);
    wait_idle();
    issue(1'b1, 32'h20, 32'h1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_wait");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 1'b1);
    wait_idle();

    // Misaligned store and load, then the aligned word they alias.
    issue(1'b1, 32'h22, 32'hFF, 1'b1);
    issue(1'b0, 32'h22, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 1'b1);
    wait_idle();

    // Random mix with random upper bits and byte offsets.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
